// File: rtl/riscv_nn_rf_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package riscv_nn_rf_pkg;

  localparam int unsigned RF_NUM_WORDS = 64;
  localparam int unsigned WB_ADDR_W    = 6;
  localparam int unsigned WB_DATA_W    = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Bit 5 selects the FP bank only when FP registers exist outside the X file.
  function automatic logic is_nil_addr(input logic [5:0] addr, input bit fpu, input bit zfinx);
    return (addr[4:0] == 5'd0) && (!(fpu && !zfinx) || !addr[5]);
  endfunction

endpackage

// File: rtl/riscv_nn_rr_pick.sv
// Find-first-set over a request mask, scanning circularly from a start pointer.
module riscv_nn_rr_pick
  import riscv_nn_rf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [PTR_W-1:0]   idx_o
);

  int unsigned j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!found_o && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/riscv_nn_rf_wb_arbiter.sv
// Round-robin arbiter sharing the two RF write ports among writeback requesters,
// with one registered stage towards the register file.
module riscv_nn_rf_wb_arbiter
  import riscv_nn_rf_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FPU        = 0,
  parameter int unsigned Zfinx      = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
  output logic [ADDR_WIDTH-1:0]                waddr_a_o,
  output logic [DATA_WIDTH-1:0]                wdata_a_o,
  output logic                                 we_a_o,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [DATA_WIDTH-1:0]                wdata_b_o,
  output logic                                 we_b_o,
  output logic                                 conflict_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      rr_q, rr_d, last_idx;
  logic                  g0_found, g1_found;
  logic [PTR_W-1:0]      g0_idx, g1_idx;
  logic [NUM_REQ-1:0]    g0_oh, g1_oh, addr_eq, mask1;
  logic                  nil0, nil1;

  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;
  logic                  we_a_q, we_b_q;

  riscv_nn_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick_g0 (
    .mask_i  (req_valid_i),
    .ptr_i   (rr_q),
    .found_o (g0_found),
    .idx_o   (g0_idx)
  );

  // G1 may scan from rr_q too: nothing valid precedes G0 in that order.
  riscv_nn_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick_g1 (
    .mask_i  (mask1),
    .ptr_i   (rr_q),
    .found_o (g1_found),
    .idx_o   (g1_idx)
  );

  always_comb begin
    addr_eq = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_eq[i] = (req_addr_i[i] == req_addr_i[g0_idx]);
    end
    g0_oh = g0_found ? (NUM_REQ'(1) << g0_idx) : '0;
    g1_oh = g1_found ? (NUM_REQ'(1) << g1_idx) : '0;
    mask1 = req_valid_i & ~g0_oh & ~addr_eq;

    nil0 = is_nil_addr(6'(req_addr_i[g0_idx]), FPU != 0, Zfinx != 0);
    nil1 = is_nil_addr(6'(req_addr_i[g1_idx]), FPU != 0, Zfinx != 0);

    last_idx = g1_found ? g1_idx : g0_idx;
    rr_d     = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;

    req_ready_o = rst ? '0 : (g0_oh | g1_oh);
    conflict_o  = !rst && g0_found && (|(req_valid_i & ~g0_oh & addr_eq));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
    end else begin
      we_b_q <= g0_found && !nil0;
      we_a_q <= g1_found && !nil1;
      if (g0_found) begin
        waddr_b_q <= req_addr_i[g0_idx];
        wdata_b_q <= req_data_i[g0_idx];
        rr_q      <= rr_d;
      end
      if (g1_found) begin
        waddr_a_q <= req_addr_i[g1_idx];
        wdata_a_q <= req_data_i[g1_idx];
      end
    end
  end

  // Write enables are masked by rst so an in-flight write is dropped in the reset cycle itself.
  assign we_a_o    = we_a_q && !rst;
  assign we_b_o    = we_b_q && !rst;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;

endmodule

// File: tb/tb_riscv_nn_rf_wb_arbiter.sv
// Directed self-checking bench for the writeback arbiter (integer RF and FPU configurations).
module tb_riscv_nn_rf_wb_arbiter;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;

  logic [3:0]           valid = '0;
  logic [3:0]           ready;
  logic [3:0][4:0]      addr  = '0;
  logic [3:0][31:0]     data  = '0;
  logic [4:0]           waddr_a, waddr_b;
  logic [31:0]          wdata_a, wdata_b;
  logic                 we_a, we_b, conflict;

  logic [3:0]           f_valid = '0;
  logic [3:0]           f_ready;
  logic [3:0][5:0]      f_addr  = '0;
  logic [3:0][31:0]     f_data  = '0;
  logic [5:0]           f_waddr_a, f_waddr_b;
  logic [31:0]          f_wdata_a, f_wdata_b;
  logic                 f_we_a, f_we_b, f_conflict;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  riscv_nn_rf_wb_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32), .FPU(0), .Zfinx(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(valid), .req_ready_o(ready), .req_addr_i(addr), .req_data_i(data),
    .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
    .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
    .conflict_o(conflict)
  );

  riscv_nn_rf_wb_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .Zfinx(0)) dut_f (
    .clk(clk), .rst(rst),
    .req_valid_i(f_valid), .req_ready_o(f_ready), .req_addr_i(f_addr), .req_data_i(f_data),
    .waddr_a_o(f_waddr_a), .wdata_a_o(f_wdata_a), .we_a_o(f_we_a),
    .waddr_b_o(f_waddr_b), .wdata_b_o(f_wdata_b), .we_b_o(f_we_b),
    .conflict_o(f_conflict)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // 1: reset held with everything valid
    valid = 4'b1111;
    addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    data  = {32'h104, 32'h103, 32'h102, 32'h101};
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", ready, 4'b0000);
      check_eq("rst_conflict", conflict, 1'b0);
      tick();
      check_eq("rst_we_a", we_a, 1'b0);
      check_eq("rst_we_b", we_b, 1'b0);
    end
    check_eq("rst_waddr_b", waddr_b, 5'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_ready", ready, 4'b0011);
    tick();
    valid = '0;
    check_eq("rel_we_b", we_b, 1'b1);
    check_eq("rel_waddr_b", waddr_b, 5'd1);
    check_eq("rel_waddr_a", waddr_a, 5'd2);

    // 2: two distinct requesters, then pointer = 3 observed via wrap-around grant
    do_reset();
    valid = 4'b0101;
    addr[0] = 5'd5; data[0] = 32'hA5;
    addr[2] = 5'd7; data[2] = 32'h77;
    #1;
    check_eq("t2_ready", ready, 4'b0101);
    check_eq("t2_conflict", conflict, 1'b0);
    tick();
    valid = '0;
    check_eq("t2_we_b", we_b, 1'b1);
    check_eq("t2_waddr_b", waddr_b, 5'd5);
    check_eq("t2_wdata_b", wdata_b, 32'hA5);
    check_eq("t2_we_a", we_a, 1'b1);
    check_eq("t2_waddr_a", waddr_a, 5'd7);
    check_eq("t2_wdata_a", wdata_a, 32'h77);
    valid = 4'b1111;
    addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    data  = {32'h104, 32'h103, 32'h102, 32'h101};
    #1;
    check_eq("t2_wrap_ready", ready, 4'b1001);
    tick();
    valid = '0;
    check_eq("t2_wrap_waddr_b", waddr_b, 5'd4);
    check_eq("t2_wrap_waddr_a", waddr_a, 5'd1);

    // 3: same-address pair is serialised
    do_reset();
    valid = 4'b1010;
    addr[1] = 5'd9; data[1] = 32'h11;
    addr[3] = 5'd9; data[3] = 32'h33;
    #1;
    check_eq("t3_ready1", ready, 4'b0010);
    check_eq("t3_conflict1", conflict, 1'b1);
    tick();
    valid = 4'b1000;
    check_eq("t3_we_b1", we_b, 1'b1);
    check_eq("t3_wdata_b1", wdata_b, 32'h11);
    check_eq("t3_we_a1", we_a, 1'b0);
    check_eq("t3_waddr_a_hold", waddr_a, 5'd0);
    #1;
    check_eq("t3_ready2", ready, 4'b1000);
    check_eq("t3_conflict2", conflict, 1'b0);
    tick();
    valid = '0;
    check_eq("t3_waddr_b2", waddr_b, 5'd9);
    check_eq("t3_wdata_b2", wdata_b, 32'h33);
    check_eq("t3_we_a2", we_a, 1'b0);

    // 4: all valid, distinct, held -> pairs {0,1},{2,3},{0,1}
    do_reset();
    valid = 4'b1111;
    addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    data  = {32'h104, 32'h103, 32'h102, 32'h101};
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("t4_ready", ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      tick();
      check_eq("t4_two_we", {we_a, we_b}, 2'b11);
      check_eq("t4_waddr_b", waddr_b, (k % 2 == 0) ? 5'd1 : 5'd3);
      check_eq("t4_waddr_a", waddr_a, (k % 2 == 0) ? 5'd2 : 5'd4);
      check_eq("t4_wdata_a", wdata_a, (k % 2 == 0) ? 32'h102 : 32'h104);
    end
    valid = '0;

    // 5: nil register on integer RF; f0 on FP RF is a real write
    do_reset();
    valid = 4'b0100;
    addr[2] = 5'd0; data[2] = 32'hDEAD;
    f_valid = 4'b0011;
    f_addr[0] = 6'h20; f_data[0] = 32'h1234;
    f_addr[1] = 6'h00; f_data[1] = 32'h5678;
    #1;
    check_eq("t5_ready", ready, 4'b0100);
    check_eq("t5_f_ready", f_ready, 4'b0011);
    tick();
    valid = '0;
    f_valid = '0;
    check_eq("t5_nil_we_b", we_b, 1'b0);
    check_eq("t5_nil_we_a", we_a, 1'b0);
    check_eq("t5_f_we_b", f_we_b, 1'b1);
    check_eq("t5_f_waddr_b", f_waddr_b, 6'h20);
    check_eq("t5_f_we_a_x0", f_we_a, 1'b0);

    // 6: reset right after a grant drops the in-flight write
    do_reset();
    valid = 4'b0011;
    addr[0] = 5'd6; data[0] = 32'h66;
    addr[1] = 5'd8; data[1] = 32'h88;
    #1;
    check_eq("t6_ready", ready, 4'b0011);
    tick();
    valid = '0;
    rst = 1'b1;
    #1;
    check_eq("t6_we_a_during", we_a, 1'b0);
    check_eq("t6_we_b_during", we_b, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("t6_we_a_after", we_a, 1'b0);
    check_eq("t6_we_b_after", we_b, 1'b0);
    tick();
    check_eq("t6_we_b_idle", we_b, 1'b0);
    check_eq("t6_waddr_b_cleared", waddr_b, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
